xwrgen2: RTL and testbench

//  Data-driven two-level write address generator; the receiving end of the stream that xaddrgen2 launches.

---
 rtl/xwrgen2.sv | 98 +++++++++
 tb/tb_xwrgen2.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/xwrgen2.sv
// xwrgen2: data-driven row/column/block write address generator for an FU output stream.
// Optional XWRGEN_DELAY_EN adds a delay port that drops the first delay accepted words after run.
module xwrgen2 #(
  parameter int MEM_ADDR_W = 10,
  parameter int PERIOD_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [MEM_ADDR_W-1:0] iterations,
  input  logic [PERIOD_W-1:0]   duty,
  input  logic [MEM_ADDR_W-1:0] start,
  input  logic [MEM_ADDR_W-1:0] incr,
  input  logic [MEM_ADDR_W-1:0] shift,
  input  logic [MEM_ADDR_W-1:0] iterations2,
  input  logic [MEM_ADDR_W-1:0] incr2,
`ifdef XWRGEN_DELAY_EN
  input  logic [PERIOD_W-1:0]   delay,
`endif
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [MEM_ADDR_W-1:0] addr,
  output logic                  we,
  output logic [DATA_W-1:0]     data_out,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [MEM_ADDR_W-1:0] addr_r, base_r, i, k;
  logic [PERIOD_W-1:0] j;
  logic acc, skip, wr, row_end, blk_end, last;
  assign in_ready = state == RUN;
  // a word arriving with run belongs to the aborted stream and is discarded
  assign acc = in_valid && in_ready && !run;
  assign wr = acc && !skip;
  assign row_end = j == duty - PERIOD_W'(1);
  assign blk_end = row_end && i == iterations - MEM_ADDR_W'(1);
  assign last = blk_end && k == iterations2 - MEM_ADDR_W'(1);
`ifdef XWRGEN_DELAY_EN
  logic [PERIOD_W-1:0] dcnt;
  assign skip = dcnt < delay;
  always_ff @(posedge clk or posedge rst)
    if (rst) dcnt <= '0;
    else if (run) dcnt <= '0;
    else if (acc && skip) dcnt <= dcnt + PERIOD_W'(1);
`else
  assign skip = 1'b0;
`endif
  always_comb
    state_nx = run ? ((|duty && |iterations && |iterations2) ? RUN : DONE) :
               (wr && last) ? DONE :
               (state == DONE) ? IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      we <= 1'b0;
      data_out <= '0;
      done <= 1'b1;
      addr_r <= '0;
      base_r <= '0;
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      state <= state_nx;
      we <= wr;
      done <= run ? 1'b0 : (state == DONE) ? 1'b1 : done;
      if (wr) begin
        addr <= addr_r;
        data_out <= in_data;
      end
      if (run) begin
        addr_r <= start;
        base_r <= start;
        i <= '0;
        j <= '0;
        k <= '0;
      end else if (wr) begin
        if (!row_end) begin
          addr_r <= addr_r + incr;
          j <= j + PERIOD_W'(1);
        end else if (!blk_end) begin
          addr_r <= addr_r + incr + shift;
          j <= '0;
          i <= i + MEM_ADDR_W'(1);
        end else if (!last) begin
          base_r <= base_r + incr2;
          addr_r <= base_r + incr2;
          j <= '0;
          i <= '0;
          k <= k + MEM_ADDR_W'(1);
        end
      end
    end
endmodule

// File: tb/tb_xwrgen2.sv
// tb_xwrgen2: randomized scoreboard bench for xwrgen2 against a nested-loop address model.
module tb_xwrgen2;
  localparam int AW = 10, PW = 8, DW = 16;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0;
  logic [AW-1:0] iterations = '0, start = '0, incr = '0, shift = '0, iterations2 = '0, incr2 = '0;
  logic [PW-1:0] duty = '0;
  logic [DW-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready, we, done;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
`ifdef XWRGEN_DELAY_EN
  logic [PW-1:0] delay = '0;
`endif
  always #5 clk = ~clk;

  xwrgen2 #(.MEM_ADDR_W(AW), .PERIOD_W(PW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .run(run), .iterations(iterations), .duty(duty), .start(start),
    .incr(incr), .shift(shift), .iterations2(iterations2), .incr2(incr2),
`ifdef XWRGEN_DELAY_EN
    .delay(delay),
`endif
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .addr(addr), .we(we),
    .data_out(data_out), .done(done)
  );

  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [AW-1:0] plist[$];
  logic [AW-1:0] pa;
  int m_state = 0;
  bit m_done = 1'b1;
  int m_skip = 0;
  int tests = 0, fails = 0;

  task automatic chk(string nm, longint act, longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // reference: the full write address sequence is the nest block -> row -> word
  always @(posedge clk)
    if (!rst) begin
      if (run) begin
        plist.delete();
        for (int kk = 0; kk < int'(iterations2); kk++)
          for (int ii = 0; ii < int'(iterations); ii++)
            for (int jj = 0; jj < int'(duty); jj++) begin
              pa = start + AW'(kk) * incr2 + AW'(ii) * (AW'(duty) * incr + shift) + AW'(jj) * incr;
              plist.push_back(pa);
            end
        m_done = 1'b0;
`ifdef XWRGEN_DELAY_EN
        m_skip = int'(delay);
`else
        m_skip = 0;
`endif
        m_state = plist.size() > 0 ? 1 : 2;
      end else if (m_state == 1) begin
        if (in_valid) begin
          if (m_skip > 0) m_skip--;
          else begin
            sb.push_back('{plist.pop_front(), in_data});
            if (plist.size() == 0) m_state = 2;
          end
        end
      end else if (m_state == 2) begin
        m_state = 0;
        m_done = 1'b1;
      end
    end

  always @(negedge clk)
    if (!rst) begin
      chk("in_ready", in_ready, m_state == 1);
      chk("done", done, m_done);
      chk("we", we, sb.size() > 0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (we) begin
          chk("addr", addr, e.a);
          chk("data_out", data_out, e.d);
        end
      end
    end

  task automatic run_case(input logic [PW-1:0] du, input logic [AW-1:0] it, input logic [AW-1:0] it2,
                          input logic [AW-1:0] st, input logic [AW-1:0] inc, input logic [AW-1:0] sh,
                          input logic [AW-1:0] inc2, input int vmode, input int abort_after);
    int cyc;
    duty = du; iterations = it; iterations2 = it2; start = st; incr = inc; shift = sh; incr2 = inc2;
    run = 1'b1;
    in_valid = 1'b1;
    in_data = DW'($urandom);
    @(negedge clk);
    run = 1'b0;
    cyc = 0;
    while (m_state != 0 && cyc < 300) begin
      in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? cyc % 2 == 0 : 1'($urandom);
      in_data = DW'($urandom);
      @(negedge clk);
      cyc++;
      if (abort_after > 0 && cyc == abort_after) break;
    end
    if (cyc == 300) chk("timeout", cyc, 0);
    if (abort_after == 0) begin
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_we", we, 0);
    chk("rst_data", data_out, 0);
    chk("rst_done", done, 1);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    run_case(4, 1, 1, 8, 1, 0, 0, 0, 0);
    run_case(2, 3, 1, 0, 1, 6, 0, 0, 0);
    run_case(2, 2, 2, 0, 1, 2, 16, 0, 0);
    run_case(3, 1, 1, 0, 10'h3FF, 0, 0, 1, 0);
    run_case(2, 2, 0, 5, 1, 0, 0, 0, 0);
    run_case(8, 1, 1, 0, 1, 0, 0, 0, 3);
    run_case(8, 1, 1, 100, 1, 0, 0, 0, 0);
`ifdef XWRGEN_DELAY_EN
    delay = 2;
    run_case(4, 1, 1, 8, 1, 0, 0, 0, 0);
`endif
    for (int t = 0; t < 40; t++) begin
`ifdef XWRGEN_DELAY_EN
      delay = PW'($urandom_range(0, 2));
`endif
      run_case(PW'($urandom_range(0, 4)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
               AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
               int'($urandom_range(0, 2)), t % 7 == 3 ? int'($urandom_range(1, 5)) : 0);
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
